// File: rtl/mem_access_if.sv
// Load/store request, response and memory-port bundle shared by the access unit
// and whatever drives it (pipeline on one side, word-wide memory on the other).
interface mem_access_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/halfword/word load-store unit in front of a word-wide memory with
// combinational read; sub-word stores use a read-modify-write sequence.
module mem_access_unit (
    input  logic          clk,
    input  logic          rst_n,
    mem_access_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP, ERR} state_t;

    state_t      state_reg;
    logic [1:0]  size_reg;
    logic        signed_reg;
    logic [1:0]  addr_lo_reg;
    logic [15:0] wdata_reg;

    logic        misaligned;
    logic [31:0] word_addr;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_value;
    logic [3:0]  lane_en;
    logic [31:0] merged;

    assign misaligned = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                        (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
    assign word_addr  = {bus.req_addr[31:2], 2'b00};

    // Little-endian lane extraction of the word currently on mem_rdata.
    always_comb begin
        ld_byte  = bus.mem_rdata[addr_lo_reg*8 +: 8];
        ld_half  = addr_lo_reg[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        ld_value = bus.mem_rdata;
        case (size_reg)
            2'b00:   ld_value = {{24{signed_reg & ld_byte[7]}}, ld_byte};
            2'b01:   ld_value = {{16{signed_reg & ld_half[15]}}, ld_half};
            default: ld_value = bus.mem_rdata;
        endcase
    end

    always_comb begin
        case (size_reg)
            2'b00:   lane_en = 4'b0001 << addr_lo_reg;
            2'b01:   lane_en = addr_lo_reg[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    end

    // Halfword lanes take alternating wdata bytes; byte lanes all take wdata[7:0].
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign merged[gi*8 +: 8] = !lane_en[gi]         ? bus.mem_rdata[gi*8 +: 8] :
                                       (size_reg == 2'b01)  ? wdata_reg[(gi%2)*8 +: 8] :
                                                              wdata_reg[7:0];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            size_reg       <= '0;
            signed_reg     <= 1'b0;
            addr_lo_reg    <= '0;
            wdata_reg      <= '0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
            bus.mem_write  <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid) begin
                        size_reg      <= bus.req_size;
                        signed_reg    <= bus.req_signed;
                        addr_lo_reg   <= bus.req_addr[1:0];
                        wdata_reg     <= bus.req_wdata[15:0];
                        bus.req_ready <= 1'b0;
                        if (misaligned) begin
                            state_reg      <= ERR;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                        end else if (!bus.req_write) begin
                            state_reg    <= RD;
                            bus.mem_addr <= word_addr;
                        end else if (bus.req_size[1]) begin
                            state_reg     <= WR;
                            bus.mem_addr  <= word_addr;
                            bus.mem_write <= 1'b1;
                            bus.mem_wdata <= bus.req_wdata;
                        end else begin
                            state_reg    <= RMW_RD;
                            bus.mem_addr <= word_addr;
                        end
                    end
                end
                RD: begin
                    state_reg      <= RESP;
                    bus.resp_rdata <= ld_value;
                    bus.resp_valid <= 1'b1;
                    bus.mem_addr   <= '0;
                end
                RMW_RD: begin
                    state_reg     <= WR;
                    bus.mem_write <= 1'b1;
                    bus.mem_wdata <= merged;
                end
                WR: begin
                    state_reg      <= RESP;
                    bus.mem_write  <= 1'b0;
                    bus.mem_wdata  <= '0;
                    bus.mem_addr   <= '0;
                    bus.resp_rdata <= '0;
                    bus.resp_valid <= 1'b1;
                end
                default: begin
                    // RESP and ERR both close out the single-cycle response.
                    state_reg      <= IDLE;
                    bus.resp_valid <= 1'b0;
                    bus.resp_err   <= 1'b0;
                    bus.resp_rdata <= '0;
                    bus.mem_write  <= 1'b0;
                    bus.mem_addr   <= '0;
                    bus.mem_wdata  <= '0;
                    bus.req_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised and directed self-checking bench for mem_access_unit against a
// word-array reference model of memory and load/store semantics.
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mem_access_if bus();

    mem_access_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];

    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];
    always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
        logic [31:0] w;
        logic [31:0] v;
        int sh;
        w  = ref_mem[a[7:2]];
        sh = 8 * a[1:0];
        if (sz[1]) return w;
        if (sz == 2'b00) begin
            v = (w >> sh) & 32'hFF;
            if (sg && v[7]) v = v | 32'hFFFF_FF00;
        end else begin
            v = (w >> sh) & 32'hFFFF;
            if (sg && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] old, input logic [1:0] sz,
                                                input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] mask;
        int sh;
        sh = 8 * a[1:0];
        if (sz[1]) return wd;
        mask = ((sz == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
        return (old & ~mask) | ((wd << sh) & mask);
    endfunction

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("ready_timeout", {31'b0, bus.req_ready}, 32'd1);
    endtask

    task automatic drive(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        bus.req_write  = w;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
    endtask

    task automatic txn(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
        logic        mis;
        int          lat;
        int          idx;
        int          first_valid;
        logic [31:0] exp_rd;
        bit          ok;
        idx = int'(a[7:2]);
        mis = ((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
        lat = mis ? 1 : ((!w || sz[1]) ? 2 : 3);
        exp_rd = (!mis && !w) ? model_load(sz, sg, a) : 32'd0;
        if (!mis && w) ref_mem[idx] = model_store(ref_mem[idx], sz, a, wd);
        first_valid = 0;
        wait_ready(ok);
        if (!ok) return;
        drive(w, sz, sg, a, wd);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int n = 1; n <= lat; n++) begin
            @(negedge clk);
            if (bus.resp_valid && first_valid == 0) first_valid = n;
            check("resp_valid", {31'b0, bus.resp_valid}, {31'b0, n == lat});
            check("req_ready_busy", {31'b0, bus.req_ready}, 32'd0);
            check("mem_write", {31'b0, bus.mem_write}, {31'b0, (w && !mis && n == lat - 1)});
            check("mem_wdata", bus.mem_wdata, (w && !mis && n == lat - 1) ? ref_mem[idx] : 32'd0);
            check("mem_addr", bus.mem_addr, (!mis && n < lat) ? {a[31:2], 2'b00} : 32'd0);
            if (n == lat) begin
                check("resp_err", {31'b0, bus.resp_err}, {31'b0, mis});
                check("resp_rdata", bus.resp_rdata, exp_rd);
            end
        end
        @(negedge clk);
        check("resp_pulse_end", {31'b0, bus.resp_valid}, 32'd0);
        check("mem_word", mem[idx], ref_mem[idx]);
        $display("txn %s size=%0d signed=%0d addr=0x%08h wdata=0x%08h -> err=%0d rdata=0x%08h latency=%0d word=0x%08h",
                 w ? "ST" : "LD", sz, sg, a, wd, mis, exp_rd, first_valid, mem[idx]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        logic [31:0] e1;
        logic [31:0] e2;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        for (int i = 0; i < 64; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[2] = 32'h0;
        ref_mem[2] = 32'h0;

        // Asynchronous reset: outputs must clear before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        check("rst_ready", {31'b0, bus.req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        check("rst_resp_err", {31'b0, bus.resp_err}, 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_mem_write", {31'b0, bus.mem_write}, 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        txn(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF);
        txn(1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
        txn(1'b1, 2'b00, 1'b1, 32'h0A, 32'h00000055);
        check("rmw_word", mem[2], 32'hDE55BEEF);
        txn(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF);
        txn(1'b0, 2'b00, 1'b1, 32'h0B, 32'h0);
        txn(1'b0, 2'b00, 1'b0, 32'h0B, 32'h0);
        txn(1'b0, 2'b01, 1'b1, 32'h08, 32'h0);
        txn(1'b0, 2'b01, 1'b0, 32'h0A, 32'h0);
        txn(1'b1, 2'b10, 1'b0, 32'h0A, 32'h11223344);
        txn(1'b0, 2'b01, 1'b0, 32'h09, 32'h0);
        check("err_word_unchanged", mem[2], 32'hDEADBEEF);

        for (int t = 0; t < 80; t++) begin
            txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                32'($urandom_range(0, 255)), $urandom);
        end

        // Back-to-back loads with req_valid held high throughout.
        e1 = model_load(2'b10, 1'b0, 32'h08);
        e2 = model_load(2'b01, 1'b0, 32'h0A);
        wait_ready(ok);
        drive(1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
        @(posedge clk);
        #1 drive(1'b0, 2'b01, 1'b0, 32'h0A, 32'h0);
        @(negedge clk);
        check("b2b_ready_rd", {31'b0, bus.req_ready}, 32'd0);
        check("b2b_valid_rd", {31'b0, bus.resp_valid}, 32'd0);
        @(negedge clk);
        check("b2b_ready_resp", {31'b0, bus.req_ready}, 32'd0);
        check("b2b_valid_resp1", {31'b0, bus.resp_valid}, 32'd1);
        check("b2b_rdata1", bus.resp_rdata, e1);
        @(negedge clk);
        check("b2b_ready_idle", {31'b0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        check("b2b_ready_rd2", {31'b0, bus.req_ready}, 32'd0);
        check("b2b_valid_rd2", {31'b0, bus.resp_valid}, 32'd0);
        @(negedge clk);
        check("b2b_valid_resp2", {31'b0, bus.resp_valid}, 32'd1);
        check("b2b_rdata2", bus.resp_rdata, e2);
        $display("txn B2B loads 0x08/0x0A -> rdata1=0x%08h rdata2=0x%08h", e1, e2);

        // Reset pulled during the WR cycle of a word store.
        wait_ready(ok);
        drive(1'b1, 2'b10, 1'b0, 32'h10, ~ref_mem[4]);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        #2;
        check("wr_before_rst", {31'b0, bus.mem_write}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_wr_mem_write", {31'b0, bus.mem_write}, 32'd0);
        check("rst_wr_ready", {31'b0, bus.req_ready}, 32'd1);
        check("rst_wr_mem_addr", bus.mem_addr, 32'd0);
        check("rst_wr_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        @(negedge clk);
        check("rst_wr_mem_word", mem[4], ref_mem[4]);
        check("rst_wr_no_resp", {31'b0, bus.resp_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_wr_no_resp_after", {31'b0, bus.resp_valid}, 32'd0);
        check("post_rst_ready", {31'b0, bus.req_ready}, 32'd1);
        $display("txn ST 0x10 aborted by reset -> word=0x%08h", mem[4]);
        txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports, one clock domain; reset asynchronous, active-low:
  clk  in  1  rising-edge clock
  rst_n  in  1  asynchronous active-low reset
  req_valid  in  1  pipeline load/store request
  req_ready  out  1  unit can accept a request
  req_write  in  1  1 = store, 0 = load
  req_size  in  2  00 byte, 01 halfword, 10 word; 11 reserved, treated as word
  req_signed  in  1  sign-extend sub-word loads
  req_addr  in  32  byte address
  req_wdata  in  32  store data, right-aligned
  resp_valid  out  1  one-cycle completion pulse
  resp_rdata  out  32  load result, extended
  resp_err  out  1  misaligned access, valid with resp_valid
  mem_write  out  1  drives Memory MemWrite
  mem_addr  out  32  drives Memory addr, always word-aligned
  mem_wdata  out  32  drives Memory write_data
  mem_rdata  in  32  from Memory read_data
REQ-002 SHALL treat Memory as follows: combinational read of mem_addr; write of mem_wdata at the rising clk edge while mem_write=1.

Function
REQ-003 SHALL implement FSM states IDLE, RD, RMW_RD, WR, RESP, ERR.
REQ-004 SHALL drive req_ready=1 only in IDLE.
REQ-005 SHALL accept a request on a rising edge with req_valid=1 and req_ready=1, latching write, size, signed, addr and wdata.
REQ-006 Misaligned means halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-007 On accept, next state SHALL be:
  - misaligned -> ERR
  - load -> RD
  - word store -> WR
  - byte/halfword store -> RMW_RD
REQ-008 In RD, RMW_RD and WR, mem_addr SHALL be {addr[31:2],2'b00}. In IDLE, RESP and ERR, mem_addr SHALL be 0.
REQ-009 In RD, SHALL capture lane-extracted mem_rdata into the result register, then go to RESP.
  - Byte lanes are little-endian: addr[1:0]=0 selects bits 7:0.
  - Halfword addr[1]=0 selects bits 15:0.
REQ-010 Extension SHALL be sign-extend when req_signed=1, else zero-extend. Word loads SHALL pass unchanged.
REQ-011 In RMW_RD, SHALL capture mem_rdata with only the addressed byte/halfword lane replaced by the low bits of wdata, then go to WR.
REQ-012 In WR, mem_write SHALL be 1 and mem_wdata SHALL be the merged word (sub-word) or wdata (word), then go to RESP.
REQ-013 mem_write SHALL be 1 only in WR. mem_wdata SHALL be 0 outside WR.
REQ-014 RESP SHALL assert resp_valid for one cycle with resp_err=0, then go to IDLE.
  - resp_rdata = result register for loads, 0 for stores.
REQ-015 ERR SHALL assert resp_valid=1, resp_err=1, resp_rdata=0 for one cycle, perform no memory access, then go to IDLE.
REQ-016 resp_valid SHALL rise this many cycles after the accept edge:
  - load: 2
  - word store: 2
  - sub-word store: 3
  - error: 1
REQ-017 Requests presented while req_ready=0 SHALL be ignored; the requester SHALL hold them.
REQ-018 Minimum issue interval SHALL be one request per (latency+1) cycles. A new request SHALL be accepted in the cycle after RESP/ERR.

Reset
REQ-019 rst_n=0 SHALL immediately force, without waiting for clk:
  - state=IDLE; internal registers=0
  - req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0
  - mem_write=0, mem_addr=0, mem_wdata=0
REQ-020 Reset asserted mid-operation SHALL abandon the operation with no response and no further memory write. A reset during WR SHALL suppress that write if rst_n is low at the edge.
REQ-021 After rst_n deasserts, the first request SHALL be accepted on the first rising edge with req_valid=1.

Verification
REQ-022 Word store addr 0x08, data 0xDEADBEEF, then word load 0x08:
  - exactly one mem_write pulse, mem_addr=0x08
  - load resp_rdata=0xDEADBEEF, resp_valid 2 cycles after accept
REQ-023 With 0x08=0xDEADBEEF, signed byte store addr 0x0A data 0x00000055:
  - one RMW_RD cycle, then one WR cycle
  - word 0x08 becomes 0xDE55BEEF
  - resp_valid 3 cycles after accept
REQ-024 With 0x08=0xDEADBEEF, loads SHALL return:
  - byte signed 0x0B -> 0xFFFFFFDE
  - byte unsigned 0x0B -> 0x000000DE
  - halfword signed 0x08 -> 0xFFFFBEEF
  - halfword unsigned 0x0A -> 0x0000DEAD
REQ-025 Word store addr 0x0A and halfword load addr 0x09:
  - each SHALL give resp_err=1 one cycle after accept
  - mem_write SHALL never assert
  - word 0x08 SHALL be unchanged
REQ-026 rst_n pulled low while in WR:
  - mem_write SHALL fall without a clk edge
  - no resp_valid
  - memory unchanged
  - req_ready=1
REQ-027 req_valid held high continuously with two loads: the second SHALL be accepted only in the cycle after the first RESP, and req_ready SHALL be 0 between accepts.
